// File: rtl/mips_fetch_decode_execute.sv
// Fetch, decode and execute stages of a 5-stage MIPS pipeline, including the
// IF/ID and ID/EX registers, register file, branch/jump resolution and the ALU.
module mips_fetch_decode_execute #(
  parameter logic [31:0] PC_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_e,
  input  logic        forward_ad,
  input  logic        forward_bd,
  input  logic [1:0]  forward_ae,
  input  logic [1:0]  forward_be,
  input  logic [31:0] alu_out_m,
  input  logic [31:0] result_w,
  input  logic        reg_write_w,
  input  logic [4:0]  write_reg_w,
  output logic [4:0]  rs_d,
  output logic [4:0]  rt_d,
  output logic        branch_d,
  output logic [4:0]  rs_e,
  output logic [4:0]  rt_e,
  output logic [4:0]  write_reg_e,
  output logic        reg_write_e,
  output logic        mem_to_reg_e,
  output logic        mem_write_e,
  output logic [31:0] alu_out_e,
  output logic [31:0] write_data_e,
  output logic        syscall_e,
  output logic [31:0] instr_e,
  output logic [31:0] a0_e,
  output logic [31:0] v0_e
);

  localparam int unsigned XLEN    = 32;
  localparam int unsigned RADDR_W = 5;
  localparam int unsigned NREGS   = 32;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_ctrl;
    logic       syscall;
  } ctrl_t;

  // Fetch
  logic [XLEN-1:0] pc, pc_plus_4, pc_next;
  // IF/ID
  logic [XLEN-1:0] instr_d, pc_plus_4_d;
  // Decode
  logic [5:0]         op, funct;
  logic [RADDR_W-1:0] rd_d;
  logic [XLEN-1:0]    sign_imm_d, rd1_d, rd2_d, a0_d, v0_d;
  logic [XLEN-1:0]    cmp_a, cmp_b, branch_target, jump_target;
  logic               is_beq, is_bne, is_j, is_jr, taken, pcsrc;
  ctrl_t              ctrl_d;
  logic [XLEN-1:0]    rf [NREGS];
  // ID/EX
  ctrl_t              ctrl_e;
  logic [XLEN-1:0]    rd1_e, rd2_e, sign_imm_e;
  logic [RADDR_W-1:0] rd_e;
  // Execute
  logic [XLEN-1:0]    src_a, pre_b, src_b;

  assign imem_addr = pc;
  assign pc_plus_4 = pc + XLEN'(4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         pc <= PC_RESET;
    else if (!stall_f) pc <= pc_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_d     <= '0;
      pc_plus_4_d <= '0;
    end else if (!stall_d) begin
      if (pcsrc) begin
        instr_d     <= '0;
        pc_plus_4_d <= '0;
      end else begin
        instr_d     <= imem_rdata;
        pc_plus_4_d <= pc_plus_4;
      end
    end
  end

  assign op         = instr_d[31:26];
  assign funct      = instr_d[5:0];
  assign rs_d       = instr_d[25:21];
  assign rt_d       = instr_d[20:16];
  assign rd_d       = instr_d[15:11];
  assign sign_imm_d = {{16{instr_d[15]}}, instr_d[15:0]};

  // Main decoder: unrecognised encodings leave every control at 0 (NOP)
  always_comb begin
    ctrl_d = '0;
    is_beq = 1'b0;
    is_bne = 1'b0;
    is_j   = 1'b0;
    is_jr  = 1'b0;
    case (op)
      6'h00: begin
        case (funct)
          6'h20, 6'h21: begin ctrl_d.reg_write = 1'b1; ctrl_d.reg_dst = 1'b1; ctrl_d.alu_ctrl = ALU_ADD; end
          6'h22:        begin ctrl_d.reg_write = 1'b1; ctrl_d.reg_dst = 1'b1; ctrl_d.alu_ctrl = ALU_SUB; end
          6'h24:        begin ctrl_d.reg_write = 1'b1; ctrl_d.reg_dst = 1'b1; ctrl_d.alu_ctrl = ALU_AND; end
          6'h25:        begin ctrl_d.reg_write = 1'b1; ctrl_d.reg_dst = 1'b1; ctrl_d.alu_ctrl = ALU_OR;  end
          6'h2A:        begin ctrl_d.reg_write = 1'b1; ctrl_d.reg_dst = 1'b1; ctrl_d.alu_ctrl = ALU_SLT; end
          6'h08:        is_jr = 1'b1;
          6'h0C:        ctrl_d.syscall = 1'b1;
          default:      ;
        endcase
      end
      6'h08, 6'h09: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_ctrl  = ALU_ADD;
      end
      6'h23: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.alu_ctrl   = ALU_ADD;
      end
      6'h2B: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_ctrl  = ALU_ADD;
      end
      6'h04:   is_beq = 1'b1;
      6'h05:   is_bne = 1'b1;
      6'h02:   is_j   = 1'b1;
      default: ;
    endcase
  end

  assign branch_d = is_beq | is_bne | is_jr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREGS); i++) rf[i] <= '0;
    end else if (reg_write_w && (write_reg_w != '0)) begin
      rf[write_reg_w] <= result_w;
    end
  end

  // Register reads with $0 hard-wired and write-through bypass of the writeback port
  function automatic logic [XLEN-1:0] rf_read(input logic [RADDR_W-1:0] a);
    if (a == '0)                                return '0;
    else if (reg_write_w && (write_reg_w == a)) return result_w;
    else                                        return rf[a];
  endfunction

  always_comb begin
    rd1_d = rf_read(rs_d);
    rd2_d = rf_read(rt_d);
    a0_d  = rf_read(RADDR_W'(4));
    v0_d  = rf_read(RADDR_W'(2));
  end

  assign cmp_a         = forward_ad ? alu_out_m : rd1_d;
  assign cmp_b         = forward_bd ? alu_out_m : rd2_d;
  assign taken         = (is_beq && (cmp_a == cmp_b)) || (is_bne && (cmp_a != cmp_b));
  assign pcsrc         = taken | is_j | is_jr;
  assign branch_target = pc_plus_4_d + {sign_imm_d[29:0], 2'b00};
  assign jump_target   = {pc_plus_4_d[31:28], instr_d[25:0], 2'b00};

  always_comb begin
    pc_next = pc_plus_4;
    if (is_jr)      pc_next = cmp_a;
    else if (is_j)  pc_next = jump_target;
    else if (taken) pc_next = branch_target;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_e     <= '0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      rs_e       <= '0;
      rt_e       <= '0;
      rd_e       <= '0;
      sign_imm_e <= '0;
      instr_e    <= '0;
      a0_e       <= '0;
      v0_e       <= '0;
    end else if (flush_e) begin
      ctrl_e     <= '0;
      rd1_e      <= '0;
      rd2_e      <= '0;
      rs_e       <= '0;
      rt_e       <= '0;
      rd_e       <= '0;
      sign_imm_e <= '0;
      instr_e    <= '0;
      a0_e       <= '0;
      v0_e       <= '0;
    end else begin
      ctrl_e     <= ctrl_d;
      rd1_e      <= rd1_d;
      rd2_e      <= rd2_d;
      rs_e       <= rs_d;
      rt_e       <= rt_d;
      rd_e       <= rd_d;
      sign_imm_e <= sign_imm_d;
      instr_e    <= instr_d;
      a0_e       <= a0_d;
      v0_e       <= v0_d;
    end
  end

  // Execute-stage forwarding; select 11 falls back to the register value
  always_comb begin
    case (forward_ae)
      2'b01:   src_a = result_w;
      2'b10:   src_a = alu_out_m;
      default: src_a = rd1_e;
    endcase
    case (forward_be)
      2'b01:   pre_b = result_w;
      2'b10:   pre_b = alu_out_m;
      default: pre_b = rd2_e;
    endcase
  end

  assign src_b        = ctrl_e.alu_src ? sign_imm_e : pre_b;
  assign write_data_e = pre_b;
  assign write_reg_e  = ctrl_e.reg_dst ? rd_e : rt_e;
  assign reg_write_e  = ctrl_e.reg_write;
  assign mem_to_reg_e = ctrl_e.mem_to_reg;
  assign mem_write_e  = ctrl_e.mem_write;
  assign syscall_e    = ctrl_e.syscall;

  always_comb begin
    case (ctrl_e.alu_ctrl)
      ALU_AND: alu_out_e = src_a & src_b;
      ALU_OR:  alu_out_e = src_a | src_b;
      ALU_ADD: alu_out_e = src_a + src_b;
      ALU_SUB: alu_out_e = src_a - src_b;
      ALU_SLT: alu_out_e = {31'b0, ($signed(src_a) < $signed(src_b))};
      default: alu_out_e = '0;
    endcase
  end

endmodule

// File: tb/tb_mips_fetch_decode_execute.sv
// Directed self-checking bench for mips_fetch_decode_execute using a small
// instruction ROM mapped at 0x00400000 and hand-encoded programs.
module tb_mips_fetch_decode_execute;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, imem_rdata;
  logic        stall_f, stall_d, flush_e, forward_ad, forward_bd;
  logic [1:0]  forward_ae, forward_be;
  logic [31:0] alu_out_m, result_w;
  logic        reg_write_w;
  logic [4:0]  write_reg_w;
  logic [4:0]  rs_d, rt_d, rs_e, rt_e, write_reg_e;
  logic        branch_d, reg_write_e, mem_to_reg_e, mem_write_e, syscall_e;
  logic [31:0] alu_out_e, write_data_e, instr_e, a0_e, v0_e;

  logic [31:0] imem [64];
  int checks = 0;
  int failures = 0;

  localparam logic [31:0] I_ADD_9_8_8  = 32'h0108_4820;
  localparam logic [31:0] I_OR_10_4_5  = 32'h0085_5025;
  localparam logic [31:0] I_BEQ_0_0_3  = 32'h1000_0003;
  localparam logic [31:0] I_JR_31      = 32'h03E0_0008;
  localparam logic [31:0] I_ADD_6_0_0  = 32'h0000_3020;
  localparam logic [31:0] I_SLT_3_1_2  = 32'h0022_182A;
  localparam logic [31:0] I_LW_8_4_9   = 32'h8D28_0004;
  localparam logic [31:0] I_SW_8_8_0   = 32'hAC08_0008;
  localparam logic [31:0] I_SYSCALL    = 32'h0000_000C;

  always #5 clk = ~clk;

  assign imem_rdata = (imem_addr[31:8] == 24'h004000) ? imem[imem_addr[7:2]] : 32'h0;

  mips_fetch_decode_execute #(.PC_RESET(32'h0040_0000)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .forward_ad(forward_ad), .forward_bd(forward_bd),
    .forward_ae(forward_ae), .forward_be(forward_be),
    .alu_out_m(alu_out_m), .result_w(result_w),
    .reg_write_w(reg_write_w), .write_reg_w(write_reg_w),
    .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d),
    .rs_e(rs_e), .rt_e(rt_e), .write_reg_e(write_reg_e),
    .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e), .mem_write_e(mem_write_e),
    .alu_out_e(alu_out_e), .write_data_e(write_data_e), .syscall_e(syscall_e),
    .instr_e(instr_e), .a0_e(a0_e), .v0_e(v0_e)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0;
  endtask

  // Leaves reset released just after an edge with PC at the reset vector
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    stall_f = 0; stall_d = 0; flush_e = 0; forward_ad = 0; forward_bd = 0;
    forward_ae = 2'b00; forward_be = 2'b00; alu_out_m = 0; result_w = 0;
    reg_write_w = 0; write_reg_w = 0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_mem();
    imem[0] = I_ADD_9_8_8;
    do_reset();
    tick();
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (imem_addr !== 32'h0040_0000) begin failures++; $display("FAIL reset_pc actual=%h required=%h", imem_addr, 32'h0040_0000); end
    checks++;
    if (instr_e !== 32'h0 || reg_write_e !== 1'b0 || alu_out_e !== 32'h0 || write_reg_e !== 5'd0) begin
      failures++;
      $display("FAIL reset_exec instr_e=%h reg_write_e=%b alu_out_e=%h write_reg_e=%0d required all 0", instr_e, reg_write_e, alu_out_e, write_reg_e);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (imem_addr !== 32'h0040_0004) begin failures++; $display("FAIL reset_pc_plus4 actual=%h required=%h", imem_addr, 32'h0040_0004); end
    tick();
    checks++;
    if (imem_addr !== 32'h0040_0008) begin failures++; $display("FAIL reset_pc_plus8 actual=%h required=%h", imem_addr, 32'h0040_0008); end
  endtask

  task automatic test_forwarding();
    clear_mem();
    imem[0] = I_ADD_9_8_8;
    do_reset();
    reg_write_w = 1'b1; write_reg_w = 5'd8; result_w = 32'd5;
    tick();
    reg_write_w = 1'b0; write_reg_w = 5'd0; result_w = 32'd3;
    tick();
    checks++;
    if (alu_out_e !== 32'd10 || write_reg_e !== 5'd9) begin
      failures++; $display("FAIL fwd_none alu=%0d wr=%0d required alu=10 wr=9", alu_out_e, write_reg_e);
    end
    forward_ae = 2'b01; forward_be = 2'b01;
    #1;
    checks++;
    if (alu_out_e !== 32'd6) begin failures++; $display("FAIL fwd_wb alu=%0d required=6", alu_out_e); end
    forward_ae = 2'b10; forward_be = 2'b10; alu_out_m = 32'd7;
    #1;
    checks++;
    if (alu_out_e !== 32'd14 || write_data_e !== 32'd7) begin
      failures++; $display("FAIL fwd_mem alu=%0d wdata=%0d required alu=14 wdata=7", alu_out_e, write_data_e);
    end
    forward_ae = 2'b11; forward_be = 2'b11;
    #1;
    checks++;
    if (alu_out_e !== 32'd10) begin failures++; $display("FAIL fwd_code11 alu=%0d required=10", alu_out_e); end
    forward_ae = 2'b00; forward_be = 2'b00;
  endtask

  task automatic test_branch();
    clear_mem();
    imem[0] = I_BEQ_0_0_3;
    imem[1] = I_ADD_9_8_8;
    do_reset();
    tick();
    checks++;
    if (branch_d !== 1'b1 || imem_addr !== 32'h0040_0004) begin
      failures++; $display("FAIL beq_decode branch_d=%b pc=%h required 1 00400004", branch_d, imem_addr);
    end
    tick();
    checks++;
    if (imem_addr !== 32'h0040_0010) begin failures++; $display("FAIL beq_target actual=%h required=%h", imem_addr, 32'h0040_0010); end
    tick();
    checks++;
    if (instr_e !== 32'h0 || reg_write_e !== 1'b0) begin
      failures++; $display("FAIL beq_squash instr_e=%h reg_write_e=%b required 0", instr_e, reg_write_e);
    end
  endtask

  task automatic test_stall();
    clear_mem();
    imem[0] = I_ADD_9_8_8;
    imem[1] = I_OR_10_4_5;
    do_reset();
    tick();
    stall_f = 1'b1; stall_d = 1'b1; flush_e = 1'b1;
    tick();
    tick();
    checks++;
    if (imem_addr !== 32'h0040_0004 || rs_d !== 5'd8 || rt_d !== 5'd8) begin
      failures++; $display("FAIL stall_hold pc=%h rs_d=%0d rt_d=%0d required 00400004 8 8", imem_addr, rs_d, rt_d);
    end
    checks++;
    if (reg_write_e !== 1'b0 || instr_e !== 32'h0) begin
      failures++; $display("FAIL stall_flush reg_write_e=%b instr_e=%h required 0", reg_write_e, instr_e);
    end
    stall_f = 1'b0; stall_d = 1'b0; flush_e = 1'b0;
    tick();
    checks++;
    if (instr_e !== I_ADD_9_8_8 || reg_write_e !== 1'b1 || imem_addr !== 32'h0040_0008) begin
      failures++; $display("FAIL stall_release instr_e=%h reg_write_e=%b pc=%h required %h 1 00400008", instr_e, reg_write_e, imem_addr, I_ADD_9_8_8);
    end
  endtask

  task automatic test_jr();
    clear_mem();
    imem[0] = I_JR_31;
    do_reset();
    reg_write_w = 1'b1; write_reg_w = 5'd31; result_w = 32'h0040_0100;
    tick();
    reg_write_w = 1'b0; write_reg_w = 5'd0; result_w = 32'h0;
    checks++;
    if (branch_d !== 1'b1) begin failures++; $display("FAIL jr_branch_d actual=%b required=1", branch_d); end
    tick();
    checks++;
    if (imem_addr !== 32'h0040_0100) begin failures++; $display("FAIL jr_target actual=%h required=%h", imem_addr, 32'h0040_0100); end
  endtask

  task automatic test_zero_slt();
    clear_mem();
    imem[1] = I_ADD_6_0_0;
    imem[3] = I_SLT_3_1_2;
    imem[4] = 32'hFFFF_FFFF;
    do_reset();
    reg_write_w = 1'b1; write_reg_w = 5'd0; result_w = 32'h0000_FFFF;
    tick();
    write_reg_w = 5'd1; result_w = 32'hFFFF_FFFF;
    tick();
    write_reg_w = 5'd2; result_w = 32'd1;
    tick();
    reg_write_w = 1'b0; write_reg_w = 5'd0; result_w = 32'h0;
    checks++;
    if (instr_e !== I_ADD_6_0_0 || alu_out_e !== 32'h0 || write_reg_e !== 5'd6) begin
      failures++; $display("FAIL zero_reg instr_e=%h alu=%h wr=%0d required %h 0 6", instr_e, alu_out_e, write_reg_e, I_ADD_6_0_0);
    end
    tick();
    tick();
    checks++;
    if (branch_d !== 1'b0) begin failures++; $display("FAIL undef_branch_d actual=%b required=0", branch_d); end
    checks++;
    if (alu_out_e !== 32'd1 || write_reg_e !== 5'd3 || v0_e !== 32'd1 || a0_e !== 32'd0) begin
      failures++; $display("FAIL slt alu=%h wr=%0d v0=%h a0=%h required 1 3 1 0", alu_out_e, write_reg_e, v0_e, a0_e);
    end
    tick();
    checks++;
    if (instr_e !== 32'hFFFF_FFFF || reg_write_e !== 1'b0 || mem_to_reg_e !== 1'b0 || mem_write_e !== 1'b0 || syscall_e !== 1'b0) begin
      failures++; $display("FAIL undef_ctrl instr_e=%h rw=%b m2r=%b mw=%b sys=%b required ffffffff 0 0 0 0", instr_e, reg_write_e, mem_to_reg_e, mem_write_e, syscall_e);
    end
  endtask

  task automatic test_mem_ops();
    clear_mem();
    imem[0] = I_LW_8_4_9;
    imem[1] = I_SW_8_8_0;
    imem[2] = I_SYSCALL;
    do_reset();
    tick();
    tick();
    checks++;
    if (reg_write_e !== 1'b1 || mem_to_reg_e !== 1'b1 || mem_write_e !== 1'b0 || write_reg_e !== 5'd8 || alu_out_e !== 32'd4) begin
      failures++; $display("FAIL lw rw=%b m2r=%b mw=%b wr=%0d alu=%0d required 1 1 0 8 4", reg_write_e, mem_to_reg_e, mem_write_e, write_reg_e, alu_out_e);
    end
    tick();
    checks++;
    if (reg_write_e !== 1'b0 || mem_write_e !== 1'b1 || alu_out_e !== 32'd8) begin
      failures++; $display("FAIL sw rw=%b mw=%b alu=%0d required 0 1 8", reg_write_e, mem_write_e, alu_out_e);
    end
    tick();
    checks++;
    if (syscall_e !== 1'b1 || reg_write_e !== 1'b0) begin
      failures++; $display("FAIL syscall sys=%b rw=%b required 1 0", syscall_e, reg_write_e);
    end
  endtask

  initial begin
    reset = 1'b1;
    stall_f = 0; stall_d = 0; flush_e = 0; forward_ad = 0; forward_bd = 0;
    forward_ae = 2'b00; forward_be = 2'b00; alu_out_m = 0; result_w = 0;
    reg_write_w = 0; write_reg_w = 0;
    clear_mem();
    test_reset();
    test_forwarding();
    test_branch();
    test_stall();
    test_jr();
    test_zero_slt();
    test_mem_ops();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_fetch_decode_execute.md
Name: mips_fetch_decode_execute

Overview:
- Front three stages of the 5-stage MIPS pipeline: fetch (PC), decode (register file, control, branch/jump resolution), execute (forwarding muxes, ALU).
- Contains the IF/ID and ID/EX pipeline registers.
- Its execute-stage outputs feed the EX/MEM register.
- The external hazard unit supplies stall, flush and forward selects.
- MEM/WB feed back ALU-out, result and register-write data.

Parameters:
- PC_RESET, 32'h0040_0000, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- imem_addr  out  32  current PC
- imem_rdata  in  32  instruction at imem_addr, combinational
- stall_f  in  1  1 = hold PC
- stall_d  in  1  1 = hold IF/ID
- flush_e  in  1  1 = load bubble into ID/EX
- forward_ad, forward_bd  in  1 each  1 = decode compare operand taken from alu_out_m
- forward_ae, forward_be  in  2 each  00 = register, 01 = result_w, 10 = alu_out_m
- alu_out_m  in  32  ALU result in MEM stage
- result_w  in  32  writeback value
- reg_write_w  in  1  register-file write enable
- write_reg_w  in  5  register-file write address
- rs_d, rt_d  out  5 each  decode source fields
- branch_d  out  1  decode instruction is beq/bne/jr
- rs_e, rt_e  out  5 each  execute source fields
- write_reg_e  out  5  execute destination register
- reg_write_e, mem_to_reg_e, mem_write_e  out  1 each  execute control
- alu_out_e  out  32  ALU result
- write_data_e  out  32  forwarded rt value (store data)
- syscall_e  out  1  syscall marker
- instr_e, a0_e, v0_e  out  32 each  instruction, $4 and $2 captured in decode

Behaviour:
- Reset (async): PC = PC_RESET; IF/ID, ID/EX and all 32 registers cleared. All execute outputs read 0; a zero instruction decodes as NOP.
- Fetch:
  - pc_plus_4 = PC + 4.
  - Next PC priority: jr > j > taken branch > pc_plus_4.
  - PC updates on the clock edge unless stall_f = 1.
- IF/ID register priority: stall_d holds; else pcsrc (taken branch, j or jr in decode) clears to 0; else loads {imem_rdata, pc_plus_4}.
- Decoded instructions:
  - R-type (op 0): add/addu 0x20/0x21, sub 0x22, and 0x24, or 0x25, slt 0x2A, jr 0x08, syscall 0x0C.
  - I-type: addi/addiu 0x08/0x09, lw 0x23, sw 0x2B, beq 0x04, bne 0x05.
  - J-type: j 0x02.
  - Anything else gives all controls 0 (NOP).
- ALU control: and 000, or 001, add 010, sub 110, slt 111 (signed).
  - lw, sw and addi use add; ALUSrc = 1; RegDst = 0.
  - Arithmetic R-type instructions use RegDst = 1.
- Register file:
  - 32x32; $0 always reads 0.
  - Written on the rising edge when reg_write_w = 1 and write_reg_w != 0.
  - Same-cycle read of the register being written returns result_w (write-through bypass).
- Branch and jump resolution (decode):
  - Compare operands: rd1/rd2, replaced by alu_out_m when forward_ad/forward_bd = 1.
  - beq is taken on equal, bne on not-equal.
  - Branch target = pc_plus_4D + (sign_ext(imm) << 2).
  - j target = {pc_plus_4D[31:28], instr[25:0], 2'b00}.
  - jr target = forwarded rd1.
- ID/EX register:
  - flush_e or reset loads all zeros (bubble).
  - Otherwise it loads control, rd1, rd2, rs, rt, rd, sign_imm, instr, $4, $2 and the syscall flag.
- Execute:
  - SrcA and the pre-SrcB value come from the forward_ae/forward_be muxes; code 11 is treated as 00.
  - write_data_e = pre-SrcB value.
  - SrcB = ALUSrc ? sign_imm : pre-SrcB.
  - write_reg_e = RegDst ? rd : rt.
  - The ALU is combinational with 32-bit wraparound and no overflow trap.
- Latency: an instruction fetched in cycle n reaches the execute outputs in cycle n+2 when there are no stalls.

Test Plan:
- Reset: assert reset mid-run → imem_addr = 0x00400000 immediately; all execute outputs 0. Release → PC advances by 4 each cycle.
- Forwarding: write reg_write_w = 1, write_reg_w = 8, result_w = 5. Then issue add $9,$8,$8 with forward_ae = forward_be = 10 and alu_out_m = 7 → alu_out_e = 14, write_reg_e = 9.
- Taken branch: beq $0,$0,+3 at 0x00400000 → next PC = 0x00400010. The following IF/ID contents are cleared, so a NOP reaches execute.
- Stall: stall_f = stall_d = 1 for 2 cycles → imem_addr and the decode instruction hold; flush_e = 1 gives reg_write_e = 0.
- jr: $31 = 0x00400100 (via writeback port), jr $31 → next PC = 0x00400100; branch_d = 1 during decode.
- $0 and slt: writeback to $0 with 0xFFFF is ignored (reads 0). slt with -1 and 1 → alu_out_e = 1. Undefined opcode 0x3F → all control outputs 0.
